// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler.
// Holds the FSM state type, default channel count and id-width function.
package edge_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int DEF_N = 4;

    // Bits needed to index v channels; at least 1 so ids never vanish.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_sched_rr_pick.sv
// Round-robin picker: first set request at or after start, with wrap.
// Purely combinational.
module rr_pick
    import edge_sched_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic           any,
    output logic [IDW-1:0] idx
);

    int c;

    // Scan offsets high to low so the smallest offset from start wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(start) + k) % N;
            if (req[c]) begin
                any = 1'b1;
                idx = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/edge_event_scheduler.sv
// Rising-edge event scheduler: per-channel pending flags, sticky overflow,
// and round-robin hand-off of one event per clock over valid/ready.
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int N = DEF_N,
    localparam int IDW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in,
    output logic           ev_valid,
    output logic [IDW-1:0] ev_id,
    input  logic           ev_ready,
    output logic [N-1:0]   overflow,
    input  logic           ovf_clr
);

    state_t         state;
    logic [N-1:0]   ff1;
    logic [N-1:0]   ff2;
    logic [N-1:0]   edge_det;
    logic [N-1:0]   pending;
    logic [N-1:0]   granted;
    logic [N-1:0]   ovf_set;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] nxt;
    logic [IDW-1:0] start;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           accept;
    logic           load;

    for (genvar i = 0; i < N; i++) begin : g_edge
        assign edge_det[i] = ff1[i] & ~ff2[i];
    end

    assign accept  = ev_valid & ev_ready;
    assign nxt     = (ev_id == IDW'(N - 1)) ? '0 : ev_id + IDW'(1);
    assign start   = (state == OFFER) ? nxt : ptr;
    assign load    = pick_any & ((state == IDLE) | accept);
    assign ovf_set = edge_det & pending & ~granted;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req  (pending),
        .start(start),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // One-hot mark of the channel moving into the output register.
    always_comb begin
        granted = '0;
        if (load) begin
            granted[pick_idx] = 1'b1;
        end
    end

    // Edge sync, pending flags and sticky overflow; a new edge beats a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff1      <= '0;
            ff2      <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            ff1      <= in;
            ff2      <= ff1;
            pending  <= (pending & ~granted) | edge_det;
            overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
        end
    end

    // Offer FSM: load from IDLE, reload on accept for 1 event per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_id    <= '0;
            ptr      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        ev_id    <= pick_idx;
                        ev_valid <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        ptr <= nxt;
                        if (pick_any) begin
                            ev_id <= pick_idx;
                        end else begin
                            ev_valid <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ev_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Watches N level inputs for rising edges and queues one pending flag per channel.
- Hands pending events one at a time to a single downstream consumer over a valid/ready handshake, with round-robin fairness.
- Sits between raw synchronised inputs (buttons, strobes) and a shared event-handling resource.
- Flags lost events with sticky per-channel overflow bits.

Parameters:
- N, 4, number of input channels (2..16).
- IDW, clog2(N), width of the event id (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  N  level inputs, already synchronised to clk.
- ev_valid  out  1  event offered to the consumer.
- ev_id  out  IDW  channel index of the offered event.
- ev_ready  in  1  consumer accepts the event when it is high together with ev_valid.
- overflow  out  N  sticky per channel: an edge was lost because that channel's event was already pending.
- ovf_clr  in  1  clears all overflow bits.

Behaviour:
- Reset, synchronous and active-high:
  - per-channel ff1/ff2 = 0, pending = 0, overflow = 0;
  - round-robin pointer ptr = 0; FSM = IDLE; ev_valid = 0, ev_id = 0.
  - Any events pending or being offered are dropped when rst is high.
- Edge detect, per channel:
  - ff1 <= in[i], ff2 <= ff1; edge[i] = ff1 & ~ff2.
  - An input already high when rst deasserts produces one edge.
  - An input held high produces exactly one edge.
- Pending, per channel, each cycle:
  - edge[i] & pending[i] & !granted[i] -> overflow[i] <= 1, pending stays 1.
  - edge[i] & granted[i] -> pending stays 1, no overflow. The edge is a new event; set wins over clear.
  - granted[i] & !edge[i] -> pending <= 0.
  - edge[i] & !pending[i] -> pending <= 1.
  - granted[i] means channel i is loaded into the output register this cycle.
- Overflow:
  - Sticky.
  - ovf_clr clears all bits, except that a bit being set in the same cycle stays 1.
- Pick: the first channel with pending = 1, searching from ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
- FSM IDLE:
  - ev_valid = 0.
  - If any pending: load ev_id = pick, ev_valid <= 1, mark pick granted, go OFFER.
- FSM OFFER:
  - ev_valid = 1; ev_id is held stable until accepted.
  - ev_valid & !ev_ready: hold everything.
  - ev_valid & ev_ready: ptr <= (ev_id+1) mod N.
    - If any pending this cycle, load the next pick in the same cycle, searching from (ev_id+1) mod N. Stay in OFFER; back-to-back throughput is 1 event per clock.
    - If nothing is pending, ev_valid <= 0 and go IDLE.
- Latency, no contention:
  - in sampled high at edge k -> ff1 = 1 after k -> pending = 1 after k+1 -> ev_valid = 1 after k+2.
- A channel whose event is currently offered may raise a new pending event. That is not an overflow.
- ev_ready while ev_valid = 0 is ignored.
- ptr only advances on accept.

Decomposition:
- Package edge_sched_pkg:
  - state enum {IDLE, OFFER} (1 bit);
  - default N;
  - clog2 function used for IDW.
- Sub-module rr_pick:
  - combinational, parameter N;
  - inputs req[N-1:0], start[IDW-1:0];
  - outputs any, idx[IDW-1:0];
  - used once, in both the IDLE load and the OFFER reload paths.
- Edge/pending/overflow logic stays inline, generated per channel.

Test Plan:
- Reset with in = 0, then in[2] rises (N=4), ev_ready = 1 -> ev_valid rises 2 cycles after in[2] is first sampled, ev_id = 2, drops the next cycle; overflow = 0.
- in[0], in[1] and in[3] rise in the same cycle, ev_ready = 1 -> ev_id sequence 0, 1, 3 on consecutive cycles, then ev_valid = 0; ptr ends at 0.
- ev_ready = 0 while ch1 is offered; ch1 pulses twice more, 3 cycles apart:
  - first pulse -> pending[1] = 1, no overflow;
  - second pulse -> overflow[1] = 1;
  - ev_id stays 1 throughout; after ready, ch1 is offered again exactly once.
- Fairness: ch0 and ch1 are re-pulsed continuously and each event is accepted immediately -> grants alternate 0, 1, 0, 1; neither channel is granted twice in a row while the other is pending.
- ovf_clr asserted in the same cycle as a new overflow on ch3 -> overflow[3] = 1 and the other bits are cleared; ovf_clr alone next cycle -> overflow = 0.
- rst pulsed while OFFER with ch2 offered and ch0 pending -> next cycle ev_valid = 0 and overflow = 0; no event appears afterwards unless a new edge occurs; in held high through rst -> one event after release.
